// File: rtl/sync_updown_counter_pkg.sv
// Shared definitions for the synchronous modulo-N up/down counter:
// the wrap/saturate mode constants and the load clamp helper.
package counter_pkg;

  typedef enum int unsigned {
    CNT_WRAP = 0,
    CNT_SAT  = 1
  } cnt_mode_e;

  // Limit a parallel-load value to the largest legal count.
  function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                             input logic [63:0] max_q);
    return (64'(value) > max_q) ? max_q[31:0] : value;
  endfunction

endpackage

// File: rtl/sync_updown_counter_next_value.sv
// Next-state logic for the counter: next count, terminal-count request and
// saturation "hit" flag, from the current state and the control inputs.
module counter_next_value
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int unsigned     SATURATE = CNT_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             hit,
  output logic [WIDTH-1:0] q_next,
  output logic             tc_next,
  output logic             hit_next
);

  localparam logic [63:0]      MAX64    = 64'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_Q    = MAX64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam bit               SAT_MODE = (SATURATE == int'(CNT_SAT));

  logic at_limit;

  always_comb begin
    q_next   = q;
    tc_next  = 1'b0;
    hit_next = hit;
    at_limit = up_dn ? (q == MAX_Q) : (q == '0);

    if (load) begin
      q_next   = WIDTH'(clamp_load(32'(load_value), MAX64));
      hit_next = 1'b0;
    end else if (en) begin
      // The limit is checked before stepping, so +/-1 never overflows.
      if (!at_limit) begin
        q_next   = up_dn ? (q + ONE) : (q - ONE);
        hit_next = 1'b0;
      end else if (!SAT_MODE) begin
        q_next   = up_dn ? '0 : MAX_Q;
        tc_next  = 1'b1;
        hit_next = 1'b0;
      end else begin
        tc_next  = !hit;
        hit_next = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sync_updown_counter.sv
// Fully synchronous modulo-N up/down counter with enable, parallel load,
// wrap or saturate mode, registered terminal-count pulse and limit flags.
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int unsigned     SATURATE = CNT_WRAP
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
);

  generate
    if (WIDTH < 1 || WIDTH > 32)
      $error("sync_updown_counter: WIDTH must be in 1..32");
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH))
      $error("sync_updown_counter: MODULUS must be in 2..2**WIDTH");
    if (SATURATE > 1)
      $error("sync_updown_counter: SATURATE must be 0 or 1");
  endgenerate

  localparam logic [63:0]      MAX64 = 64'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_Q = MAX64[WIDTH-1:0];

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             hit_q, hit_d;

  counter_next_value #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .SATURATE(SATURATE)
  ) u_next (
    .q         (q_q),
    .en        (en),
    .up_dn     (up_dn),
    .load      (load),
    .load_value(load_value),
    .hit       (hit_q),
    .q_next    (q_d),
    .tc_next   (tc_d),
    .hit_next  (hit_d)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      hit_q <= hit_d;
    end
  end

  assign q      = q_q;
  assign tc     = tc_q;
  assign at_max = (q_q == MAX_Q);
  assign at_min = (q_q == '0);

endmodule

// File: tb/tb_sync_updown_counter.sv
// Bench for sync_updown_counter: three configurations share one stimulus
// stream and are checked every cycle against an integer model.
module tb_sync_updown_counter;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b0;
  logic       load = 1'b0;
  logic [7:0] lv = '0;

  logic [3:0] q0, q1;
  logic [7:0] q2;
  logic       tc0, tc1, tc2, amax0, amax1, amax2, amin0, amin1, amin2;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clock = ~clock;

  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_wrap (
    .clock(clock), .clear(clear), .en(en), .up_dn(up_dn), .load(load),
    .load_value(lv[3:0]), .q(q0), .tc(tc0), .at_max(amax0), .at_min(amin0));

  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_sat (
    .clock(clock), .clear(clear), .en(en), .up_dn(up_dn), .load(load),
    .load_value(lv[3:0]), .q(q1), .tc(tc1), .at_max(amax1), .at_min(amin1));

  sync_updown_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(0)) dut_w8 (
    .clock(clock), .clear(clear), .en(en), .up_dn(up_dn), .load(load),
    .load_value(lv), .q(q2), .tc(tc2), .at_max(amax2), .at_min(amin2));

  // Integer reference model, one slot per configuration
  int mod_n[3]  = '{10, 10, 256};
  int sat_m[3]  = '{0, 1, 0};
  int lv_msk[3] = '{15, 15, 255};
  int mq[3];
  int mtc[3];
  int mblk[3];
  bit model_valid = 1'b0;

  always @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      int v;
      if (clear) begin
        mq[k] = 0; mtc[k] = 0; mblk[k] = 0;
      end else if (load) begin
        v = int'(lv) & lv_msk[k];
        mq[k] = (v > mod_n[k] - 1) ? mod_n[k] - 1 : v;
        mtc[k] = 0; mblk[k] = 0;
      end else if (en && up_dn && mq[k] < mod_n[k] - 1) begin
        mq[k]++; mtc[k] = 0; mblk[k] = 0;
      end else if (en && !up_dn && mq[k] > 0) begin
        mq[k]--; mtc[k] = 0; mblk[k] = 0;
      end else if (en && sat_m[k] == 0) begin
        mq[k] = up_dn ? 0 : mod_n[k] - 1;
        mtc[k] = 1; mblk[k] = 0;
      end else if (en) begin
        mtc[k] = (mblk[k] == 0) ? 1 : 0;
        mblk[k] = 1;
      end else begin
        mtc[k] = 0;
      end
    end
    if (clear) model_valid = 1'b1;
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input int q, input logic tc,
                          input logic amax, input logic amin);
    cmp($sformatf("model_q[%0d]", k), q, mq[k]);
    cmp($sformatf("model_tc[%0d]", k), int'(tc), mtc[k]);
    cmp($sformatf("model_at_max[%0d]", k), int'(amax), int'(mq[k] == mod_n[k] - 1));
    cmp($sformatf("model_at_min[%0d]", k), int'(amin), int'(mq[k] == 0));
  endtask

  always @(negedge clock) begin
    if (model_valid) begin
      cmp_inst(0, int'(q0), tc0, amax0, amin0);
      cmp_inst(1, int'(q1), tc1, amax1, amin1);
      cmp_inst(2, int'(q2), tc2, amax2, amin2);
    end
  end

  task automatic step(input logic c, input logic l, input logic e,
                      input logic u, input logic [7:0] v);
    clear = c; load = l; en = e; up_dn = u; lv = v;
    @(posedge clock);
    #1;
  endtask

  int up_seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int sat_q[5]   = '{8, 9, 9, 9, 9};
  int sat_tc[5]  = '{0, 0, 1, 0, 0};
  int dn_seq[3]  = '{9, 8, 7};

  initial begin
    step(1, 0, 0, 0, 0);
    cmp("reset_q", int'(q0), 0);
    cmp("reset_tc", int'(tc0), 0);
    cmp("reset_at_min", int'(amin0), 1);
    cmp("reset_at_max", int'(amax0), 0);

    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, 1, 0);
      cmp("wrap_up_q", int'(q0), up_seq[i]);
      cmp("wrap_up_tc", int'(tc0), int'(i == 9));
      cmp("wrap_up_at_max", int'(amax0), int'(up_seq[i] == 9));
    end
    cmp("sat_top_hold_q", int'(q1), 9);
    cmp("w8_up_q", int'(q2), 12);

    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0);
      cmp("wrap_dn_q", int'(q0), dn_seq[i]);
      cmp("wrap_dn_tc", int'(tc0), int'(i == 0));
      cmp("sat_bottom_q", int'(q1), 0);
      cmp("sat_bottom_tc", int'(tc1), int'(i == 0));
      cmp("sat_bottom_at_min", int'(amin1), 1);
    end

    step(0, 1, 0, 0, 7);
    cmp("sat_load_q", int'(q1), 7);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 1, 0);
      cmp("sat_up_q", int'(q1), sat_q[i]);
      cmp("sat_up_tc", int'(tc1), sat_tc[i]);
    end
    step(0, 0, 1, 0, 0);
    cmp("sat_back_q", int'(q1), 8);
    cmp("sat_back_tc", int'(tc1), 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    cmp("sat_rehit_q", int'(q1), 9);
    cmp("sat_rehit_tc", int'(tc1), 1);

    step(0, 1, 0, 0, 13);
    cmp("load_clamp_q", int'(q0), 9);
    cmp("load_clamp_tc", int'(tc0), 0);
    step(0, 1, 1, 1, 4);
    cmp("load_over_en_q", int'(q0), 4);

    step(0, 1, 0, 0, 5);
    cmp("prio_pre_q", int'(q0), 5);
    step(1, 1, 1, 1, 3);
    cmp("prio_clear_q", int'(q0), 0);
    cmp("prio_clear_tc", int'(tc0), 0);
    cmp("prio_clear_q_w8", int'(q2), 0);

    step(0, 1, 0, 0, 9);
    step(0, 0, 1, 1, 0);
    cmp("pend_tc_pulse", int'(tc0), 1);
    cmp("pend_q", int'(q0), 0);
    step(1, 0, 1, 1, 0);
    cmp("pend_tc_cut", int'(tc0), 0);
    cmp("pend_q_after", int'(q0), 0);

    step(0, 1, 0, 0, 255);
    cmp("w8_load_q", int'(q2), 255);
    cmp("w8_at_max", int'(amax2), 1);
    cmp("w8_narrow_clamp_q", int'(q0), 9);
    step(0, 0, 1, 1, 0);
    cmp("w8_roll_q", int'(q2), 0);
    cmp("w8_roll_tc", int'(tc2), 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0);
      cmp("w8_hold_q", int'(q2), 0);
      cmp("w8_hold_tc", int'(tc2), 0);
    end

    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
